// File: rtl/icache_miss_server_pkg.sv
// Shared types and sizes for the icache miss server: queue entry, FSM states,
// address/line widths and the line-alignment helper.
package icache_miss_server_pkg;

  localparam int PHY_ADDR_W        = 32;
  localparam int THR_PER_CORE      = 4;
  localparam int THR_PER_CORE_W    = $clog2(THR_PER_CORE);
  localparam int ICACHE_LINE_W     = 128;
  localparam int MISS_SERVER_DEPTH = THR_PER_CORE;

  typedef logic [PHY_ADDR_W-1:0]     phy_addr_t;
  typedef logic [THR_PER_CORE_W-1:0] thr_id_t;
  typedef logic [ICACHE_LINE_W-1:0]  line_t;

  typedef struct packed {
    phy_addr_t addr;
    thr_id_t   thread_id;
  } icache_miss_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERROR,
    RESPOND
  } miss_server_state_t;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic phy_addr_t line_align(input phy_addr_t addr, input int line_bytes);
    phy_addr_t mask;
    mask = phy_addr_t'(line_bytes - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_miss_server_if.sv
// Fetch-side and memory-side signals of the miss server; slave is the server's
// view, master is the view of whoever drives fetch requests and models memory.
interface icache_miss_server_if
  import icache_miss_server_pkg::*;
;
  logic      req_valid_miss;
  phy_addr_t req_addr;
  thr_id_t   req_thread_id;

  logic      rsp_valid_miss;
  thr_id_t   rsp_thread_id;
  line_t     rsp_data_miss;
  logic      rsp_bus_error;

  logic      mm_req_valid;
  phy_addr_t mm_req_addr;
  logic      mm_req_ready;
  logic      mm_rsp_valid;
  line_t     mm_rsp_data;

  modport slave (
    input  req_valid_miss, req_addr, req_thread_id,
    output rsp_valid_miss, rsp_thread_id, rsp_data_miss, rsp_bus_error,
    output mm_req_valid, mm_req_addr,
    input  mm_req_ready, mm_rsp_valid, mm_rsp_data
  );

  modport master (
    output req_valid_miss, req_addr, req_thread_id,
    input  rsp_valid_miss, rsp_thread_id, rsp_data_miss, rsp_bus_error,
    input  mm_req_valid, mm_req_addr,
    output mm_req_ready, mm_rsp_valid, mm_rsp_data
  );

endinterface

// File: rtl/icache_miss_server_fifo.sv
// In-order request queue for pending misses; a push is accepted when full only
// if the same cycle also pops, so the slot is reused and the count is unchanged.
module miss_req_fifo
  import icache_miss_server_pkg::*;
#(
  parameter int DEPTH = MISS_SERVER_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_push,
  input  icache_miss_entry_t i_push_data,
  input  logic               i_pop,
  output icache_miss_entry_t o_pop_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  icache_miss_entry_t r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign w_pop_ok   = i_pop && !o_empty;
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_pop_data = r_mem[r_rd_ptr];

  // NOTE: sequential state is written with <= so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; empty slots are never read because the count gates pops.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/icache_miss_server.sv
// Serves icache line misses one at a time: queues requests, reads each line from
// main memory (or flags an out-of-range address) and returns it tagged with the thread.
module icache_miss_server
  import icache_miss_server_pkg::*;
#(
  parameter int        DEPTH      = MISS_SERVER_DEPTH,
  parameter phy_addr_t ADDR_LIMIT = 32'h0010_0000,
  parameter int        LINE_BYTES = ICACHE_LINE_W / 8
) (
  input  logic                clock,
  input  logic                reset,
  icache_miss_server_if.slave bus,
  output logic                overflow
);

  miss_server_state_t r_state;
  miss_server_state_t w_next_state;
  icache_miss_entry_t w_req_entry;
  icache_miss_entry_t w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  phy_addr_t          r_cur_addr;
  thr_id_t            r_cur_tid;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  thr_id_t            r_rsp_tid;
  line_t              r_rsp_data;
  logic               r_overflow;

  assign w_req_entry = '{addr: line_align(bus.req_addr, LINE_BYTES),
                         thread_id: bus.req_thread_id};

  miss_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (bus.req_valid_miss),
    .i_push_data (w_req_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_next_state     = r_state;
    w_pop            = 1'b0;
    bus.mm_req_valid = 1'b0;
    bus.mm_req_addr  = '0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = (w_head.addr >= ADDR_LIMIT) ? ERROR : ISSUE;
        end
      end
      ISSUE: begin
        bus.mm_req_valid = 1'b1;
        bus.mm_req_addr  = r_cur_addr;
        if (bus.mm_req_ready) w_next_state = WAIT;
      end
      WAIT:    if (bus.mm_rsp_valid) w_next_state = RESPOND;
      ERROR:   w_next_state = RESPOND;
      RESPOND: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Response registers load on the way into RESPOND so the pulse lines up with that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_cur_tid   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= 1'b0;
      if (w_pop) begin
        r_cur_addr <= w_head.addr;
        r_cur_tid  <= w_head.thread_id;
      end
      if (r_state == WAIT && bus.mm_rsp_valid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_tid   <= r_cur_tid;
        r_rsp_data  <= bus.mm_rsp_data;
      end else if (r_state == ERROR) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_tid   <= r_cur_tid;
        r_rsp_data  <= '0;
      end
      if (bus.req_valid_miss && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign bus.rsp_valid_miss = r_rsp_valid;
  assign bus.rsp_bus_error  = r_rsp_err;
  assign bus.rsp_thread_id  = r_rsp_tid;
  assign bus.rsp_data_miss  = r_rsp_data;
  assign overflow           = r_overflow;

endmodule

// File: tb/tb_icache_miss_server.sv
// Directed bench for icache_miss_server: a behavioural memory with programmable
// stall/latency, and a response scoreboard filled as requests are driven.
module tb_icache_miss_server;
  import icache_miss_server_pkg::*;

  localparam phy_addr_t ADDR_LIMIT = 32'h0010_0000;
  localparam int        LINE_BYTES = 16;

  typedef struct {
    thr_id_t tid;
    line_t   data;
    logic    err;
  } rsp_exp_t;

  logic clock;
  logic reset;
  logic overflow;

  icache_miss_server_if bus ();

  icache_miss_server dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  rsp_exp_t  sb_q[$];
  phy_addr_t mm_q[$];
  int        checks;
  int        failures;
  int        mem_ready_stall;
  int        mem_rsp_lat;
  bit        mem_enable;
  bit        mem_rsp_pending;
  int        spur_req;

  function automatic line_t mem_line(input phy_addr_t a);
    return {16{8'hA5}} ^ line_t'(a);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_rsp_valid"}, 128'(bus.rsp_valid_miss), '0);
    check({pfx, "_rsp_tid"},   128'(bus.rsp_thread_id),  '0);
    check({pfx, "_rsp_data"},  bus.rsp_data_miss,        '0);
    check({pfx, "_rsp_err"},   128'(bus.rsp_bus_error),  '0);
    check({pfx, "_mm_valid"},  128'(bus.mm_req_valid),   '0);
    check({pfx, "_mm_addr"},   128'(bus.mm_req_addr),    '0);
    check({pfx, "_overflow"},  128'(overflow),           '0);
  endtask

  // Drives one request for a cycle; answered requests get their expectations queued.
  task automatic send(input phy_addr_t addr, input thr_id_t tid, input bit answered);
    phy_addr_t aligned;
    aligned = line_align(addr, LINE_BYTES);
    bus.req_valid_miss = 1'b1;
    bus.req_addr       = addr;
    bus.req_thread_id  = tid;
    if (answered) begin
      if (aligned >= ADDR_LIMIT) begin
        sb_q.push_back('{tid: tid, data: '0, err: 1'b1});
      end else begin
        sb_q.push_back('{tid: tid, data: mem_line(aligned), err: 1'b0});
        mm_q.push_back(aligned);
      end
    end
    @(negedge clock);
    bus.req_valid_miss = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_drain"}, 128'(sb_q.size()), '0);
    repeat (2) @(negedge clock);
  endtask

  // Memory model: accepts after mem_ready_stall cycles, answers mem_rsp_lat cycles later.
  initial begin : mem_model
    int        stall_cnt;
    int        rsp_cnt;
    int        spur_done;
    bit        stalling;
    phy_addr_t held;
    stall_cnt = 0;
    rsp_cnt   = 0;
    spur_done = 0;
    stalling  = 1'b0;
    held      = '0;
    mem_rsp_pending  = 1'b0;
    bus.mm_req_ready = 1'b0;
    bus.mm_rsp_valid = 1'b0;
    bus.mm_rsp_data  = '0;
    forever begin
      @(negedge clock);
      bus.mm_req_ready = 1'b0;
      bus.mm_rsp_valid = 1'b0;
      if (reset) stalling = 1'b0;
      if (mem_rsp_pending) begin
        if (rsp_cnt == 0) begin
          bus.mm_rsp_valid = 1'b1;
          bus.mm_rsp_data  = mem_line(held);
          mem_rsp_pending  = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end else if (spur_done != spur_req) begin
        bus.mm_rsp_valid = 1'b1;
        bus.mm_rsp_data  = '1;
        spur_done        = spur_req;
      end else if (bus.mm_req_valid && !reset) begin
        if (!stalling) begin
          held = bus.mm_req_addr;
          if (mm_q.size() == 0) check("mm_req_unexpected", 128'(bus.mm_req_valid), '0);
          else                  check("mm_req_addr", 128'(bus.mm_req_addr), 128'(mm_q.pop_front()));
          stalling  = 1'b1;
          stall_cnt = 0;
        end else begin
          check("mm_req_addr_stable", 128'(bus.mm_req_addr), 128'(held));
        end
        if (mem_enable && stall_cnt >= mem_ready_stall) begin
          bus.mm_req_ready = 1'b1;
          rsp_cnt          = mem_rsp_lat - 1;
          mem_rsp_pending  = 1'b1;
          stalling         = 1'b0;
        end else begin
          stall_cnt++;
        end
      end else if (stalling && !reset) begin
        check("mm_req_valid_held", 128'(bus.mm_req_valid), 128'(1));
      end
    end
  end

  initial begin : rsp_monitor
    rsp_exp_t e;
    forever begin
      @(negedge clock);
      if (bus.rsp_valid_miss === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 128'(bus.rsp_valid_miss), '0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_tid",  128'(bus.rsp_thread_id), 128'(e.tid));
          check("rsp_data", bus.rsp_data_miss,       e.data);
          check("rsp_err",  128'(bus.rsp_bus_error), 128'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    checks          = 0;
    failures        = 0;
    mem_ready_stall = 0;
    mem_rsp_lat     = 3;
    mem_enable      = 1'b1;
    spur_req        = 0;
    reset              = 1'b1;
    bus.req_valid_miss = 1'b0;
    bus.req_addr       = '0;
    bus.req_thread_id  = '0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single miss: aligned address out two cycles after the request.
    send(32'h0000_1234, 2'd1, 1'b1);
    check("miss_mm_valid_early", 128'(bus.mm_req_valid), '0);
    @(negedge clock);
    check("miss_mm_valid_lat2", 128'(bus.mm_req_valid), 128'(1));
    check("miss_mm_addr", 128'(bus.mm_req_addr), 128'(32'h0000_1230));
    drain("single", 50);

    // Memory response while idle must not produce a fill.
    spur_req++;
    repeat (6) begin
      @(negedge clock);
      check("spurious_no_rsp", 128'(bus.rsp_valid_miss), '0);
    end

    // Out-of-range address: error response three cycles after the request.
    send(ADDR_LIMIT, 2'd2, 1'b1);
    n = 1;
    while (bus.rsp_valid_miss !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("err_latency", 128'(n), 128'(3));
    drain("error", 20);

    // Four back-to-back misses with a stalling memory; answers stay in order.
    mem_ready_stall = 5;
    for (int i = 0; i < 4; i++) send(32'h0004_0003 + phy_addr_t'(i * 64), thr_id_t'(i), 1'b1);
    drain("order", 400);
    check("order_overflow", 128'(overflow), '0);

    // Five requests fit (one in service, four queued); the sixth is dropped.
    mem_enable = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h0008_0005 + phy_addr_t'(i * 16), thr_id_t'(i % 4), 1'b1);
    repeat (2) @(negedge clock);
    check("ovf_not_yet", 128'(overflow), '0);
    send(32'h0009_0000, 2'd3, 1'b0);
    check("ovf_set", 128'(overflow), 128'(1));

    // Release memory; push into the full queue in the cycle the head pops.
    mem_ready_stall = 0;
    mem_rsp_lat     = 2;
    mem_enable      = 1'b1;
    n = 0;
    while (bus.rsp_valid_miss !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("full_first_rsp", 128'(bus.rsp_valid_miss), 128'(1));
    @(negedge clock);
    send(32'h000A_0008, 2'd1, 1'b1);
    drain("full_swap", 300);
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Reset while waiting on memory; the late memory reply must be ignored.
    mem_rsp_lat = 8;
    send(32'h0000_3000, 2'd2, 1'b1);
    n = 0;
    while (!mem_rsp_pending && n < 10) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("wait_mm_valid_low", 128'(bus.mm_req_valid), '0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    sb_q.delete();
    check_outputs_zero("wait_reset");
    reset = 1'b0;
    repeat (12) begin
      @(negedge clock);
      check("post_reset_no_rsp", 128'(bus.rsp_valid_miss), '0);
    end

    // Block still serves normally after the abandoned access.
    mem_rsp_lat = 1;
    send(32'h0000_0044, 2'd3, 1'b1);
    drain("recover", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
